// File: rtl/data_memory_responder.sv
// data_memory_responder: valid/ready data-memory responder with fixed access latency
module data_memory_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);
  localparam int IW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state;
  logic [3:0]  cnt;
  logic        write_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] mem [DEPTH_WORDS];
  logic        accept;
  logic        enter;
  logic        a_err;
  logic [IW-1:0] idx;
  assign accept = state == IDLE && req_valid && req_ready;
  assign enter  = state == WAIT && cnt == 4'd0;
  assign a_err  = addr_q[2:0] != 3'd0 || {3'd0, addr_q[63:3]} >= 64'(DEPTH_WORDS);
  assign idx    = addr_q[IW+2:3];
  // Array write happens once, on the edge that enters RESP; contents survive reset
  always_ff @(posedge clk)
    if (enter && write_q && !a_err) mem[idx] <= wdata_q;
  // Transaction FSM: the wait count starts at LATENCY so RESP is entered LATENCY+1 edges after accept
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
      cnt        <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else if (accept) begin
      state     <= WAIT;
      req_ready <= 1'b0;
      busy      <= 1'b1;
      cnt       <= 4'(LATENCY);
      write_q   <= req_write;
      addr_q    <= req_addr;
      wdata_q   <= req_wdata;
    end else if (enter) begin
      state      <= RESP;
      resp_valid <= 1'b1;
      resp_err   <= a_err;
      resp_rdata <= (a_err || write_q) ? 64'd0 : mem[idx];
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
    end else if (state == RESP && resp_ready) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
    end else if (state == IDLE) begin
      req_ready <= 1'b1;
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: scoreboard bench for a LATENCY=2 and a LATENCY=0 responder
module tb_data_memory_responder;
  localparam int LAT0 = 2;
  localparam int LAT1 = 0;
  localparam int DEP0 = 1024;
  localparam int DEP1 = 16;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [63:0] req_addr [2];
  logic [63:0] req_wdata [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [63:0] resp_rdata [2];
  logic        resp_err [2];
  logic        busy [2];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc [2];
  logic rv_prev [2];
  typedef struct {
    int          d;
    logic        w;
    logic        err;
    logic [63:0] idx;
    logic [63:0] wd;
    logic [63:0] rd;
  } exp_t;
  exp_t sb [$];
  logic [63:0] mdl [longint unsigned];

  data_memory_responder #(.DEPTH_WORDS(DEP0), .LATENCY(LAT0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .busy(busy[0])
  );
  data_memory_responder #(.DEPTH_WORDS(DEP1), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .busy(busy[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int d);
    return d == 0 ? LAT0 : LAT1;
  endfunction
  function automatic int depth(input int d);
    return d == 0 ? DEP0 : DEP1;
  endfunction
  function automatic longint unsigned key(input int d, input logic [63:0] idx);
    return (64'(d) << 62) | idx;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Monitor: push expectations at accept, compare at response handshake, track latency
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      if (reset && req_valid[d] && req_ready[d]) begin
        e.d   = d;
        e.w   = req_write[d];
        e.idx = req_addr[d] >> 3;
        e.wd  = req_wdata[d];
        e.err = req_addr[d][2:0] != 3'd0 || (req_addr[d] >> 3) >= 64'(depth(d));
        e.rd  = (e.err || e.w) ? 64'd0 : (mdl.exists(key(d, e.idx)) ? mdl[key(d, e.idx)] : 64'd0);
        sb.push_back(e);
        acc_cyc[d] = cyc + 1;
      end
      if (resp_valid[d] && !rv_prev[d]) check("latency", 64'(cyc - acc_cyc[d]), 64'(lat(d) + 1));
      if (resp_valid[d] && resp_ready[d]) begin
        if (sb.size() == 0) check("unexpected_resp", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          check("resp_dut", 64'(d), 64'(e.d));
          check("resp_rdata", resp_rdata[d], e.rd);
          check("resp_err", 64'(resp_err[d]), 64'(e.err));
          if (e.w && !e.err) mdl[key(d, e.idx)] = e.wd;
        end
      end
      rv_prev[d] = resp_valid[d];
    end
  end

  task automatic wait_accept(input int d, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[d] && n < 20);
    check(tag, 64'(req_ready[d]), 64'd1);
  endtask

  // One transaction; hold>0 keeps resp_ready low that many cycles while offering a stray request
  task automatic xact(input int d, input logic w, input logic [63:0] a, input logic [63:0] wd, input int hold);
    logic [63:0] rd0;
    int n;
    req_valid[d] = 1'b1; req_write[d] = w; req_addr[d] = a; req_wdata[d] = wd;
    resp_ready[d] = hold == 0;
    wait_accept(d, "accept_timeout");
    @(posedge clk); #1;
    req_valid[d] = 1'b0; req_write[d] = !w; req_addr[d] = ~a; req_wdata[d] = ~wd;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid[d] && n < 40);
    check("resp_timeout", 64'(resp_valid[d]), 64'd1);
    rd0 = resp_rdata[d];
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 64'(resp_valid[d]), 64'd1);
      check("hold_rdata", resp_rdata[d], rd0);
      check("hold_req_ready", 64'(req_ready[d]), 64'd0);
      check("hold_busy", 64'(busy[d]), 64'd1);
      @(posedge clk); #1;
      req_valid[d] = 1'b1; req_write[d] = 1'b1; req_addr[d] = a; req_wdata[d] = ~wd;
      @(negedge clk);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      req_valid[d] = 1'b0; resp_ready[d] = 1'b1;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (resp_valid[d] && n < 5);
    check("resp_drop", 64'(resp_valid[d]), 64'd0);
    check("idle_rdata", resp_rdata[d], 64'd0);
    check("idle_err", 64'(resp_err[d]), 64'd0);
    check("idle_busy", 64'(busy[d]), 64'd0);
    check("idle_req_ready", 64'(req_ready[d]), 64'd1);
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
  endtask

  initial begin
    int prev;
    int n;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
      resp_ready[d] = 1'b0; rv_prev[d] = 1'b0; acc_cyc[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_req_ready", 64'(req_ready[d]), 64'd0);
      check("rst_resp_valid", 64'(resp_valid[d]), 64'd0);
      check("rst_rdata", resp_rdata[d], 64'd0);
      check("rst_err", 64'(resp_err[d]), 64'd0);
      check("rst_busy", 64'(busy[d]), 64'd0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    // store/load round trip
    xact(0, 1'b1, 64'h10, 64'hDEAD_BEEF_0123_4567, 0);
    xact(0, 1'b0, 64'h10, 64'h0, 0);
    // error cases and boundaries
    xact(0, 1'b1, 64'h0, 64'h1111_2222_3333_4444, 0);
    xact(0, 1'b0, 64'h13, 64'h0, 0);
    xact(0, 1'b1, 64'(8 * DEP0), 64'hBAD0_BAD0_BAD0_BAD0, 0);
    xact(0, 1'b1, 64'h8000_0000_0000_0010, 64'hBAD1_BAD1_BAD1_BAD1, 0);
    xact(0, 1'b0, 64'h0, 64'h0, 0);
    xact(0, 1'b1, 64'(8 * DEP0 - 8), 64'hFEED_FACE_CAFE_F00D, 0);
    xact(0, 1'b0, 64'(8 * DEP0 - 8), 64'h0, 0);
    // response stall with a stray request offered meanwhile
    xact(0, 1'b0, 64'h10, 64'h0, 5);
    xact(0, 1'b0, 64'h10, 64'h0, 0);
    // zero-latency instance
    xact(1, 1'b1, 64'h0, 64'h0123_4567_89AB_CDEF, 0);
    xact(1, 1'b0, 64'h0, 64'h0, 0);
    xact(1, 1'b0, 64'(8 * DEP1), 64'h0, 0);
    // reset during WAIT of a store must not commit it
    xact(0, 1'b1, 64'h20, 64'h5, 0);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 64'h20; req_wdata[0] = 64'h99;
    wait_accept(0, "abort_accept");
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("abort_req_ready", 64'(req_ready[0]), 64'd0);
    check("abort_resp_valid", 64'(resp_valid[0]), 64'd0);
    check("abort_rdata", resp_rdata[0], 64'd0);
    check("abort_err", 64'(resp_err[0]), 64'd0);
    check("abort_busy", 64'(busy[0]), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("release_req_ready0", 64'(req_ready[0]), 64'd0);
    @(negedge clk);
    check("release_req_ready1", 64'(req_ready[0]), 64'd1);
    xact(0, 1'b0, 64'h20, 64'h0, 0);
    // back-to-back loads: accept, LATENCY+1 edges to RESP, handshake edge, then next accept
    for (int i = 0; i < 4; i++) xact(0, 1'b1, 64'h100 + 64'(8 * i), 64'hA0 + 64'(i), 0);
    resp_ready[0] = 1'b1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 64'h100 + 64'(8 * i);
      wait_accept(0, "b2b_accept");
      if (i > 0) check("b2b_interval", 64'(cyc + 1 - prev), 64'(LAT0 + 3));
      prev = cyc + 1;
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while ((sb.size() != 0 || resp_valid[0]) && n < 50);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
